uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Configurable UART transmitter; the parametrised successor to uart_tx. It adds selectable data width, parity, stop-bit count and an internal transmit FIFO. Bytes are queued over a valid/ready handshake and serialised on tx with no idle gap between queued frames. It sits between any byte producer and the board UART pin.

Parameters:
MAIN_CLK, 12000000, clk frequency in Hz.
BAUD, 115200, line rate in baud. CLKS_PER_BIT = MAIN_CLK/BAUD (integer division). Elaboration error if < 1.
DATA_BITS, 8, data bits per frame. Legal range 5..9.
PARITY, 0, 0 = none, 1 = even, 2 = odd. Any other value is an elaboration error.
STOP_BITS, 1, stop bits per frame, 1 or 2.
FIFO_DEPTH, 4, transmit FIFO entries. Power of two, minimum 2.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
data_in  in  DATA_BITS  word to transmit.
data_in_valid  in  1  data_in is valid.
data_in_ready  out  1  FIFO can accept a word.
tx  out  1  serial line, idle high; driven from a flop.
busy  out  1  frame in progress or FIFO non-empty.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - tx=1, state=IDLE, FIFO emptied, fifo_level=0, busy=0, all counters cleared.
  - data_in_ready=1 once the FIFO is empty.
  - Reset mid-frame aborts the frame immediately (tx=1) and drops all queued words.
- Handshake:
  - A word is written on a rising edge with data_in_valid && data_in_ready.
  - data_in_ready = (fifo_level < FIFO_DEPTH), computed combinationally from registered occupancy. There is no same-cycle pass-through when full.
  - A pop in cycle N frees a slot, so data_in_ready rises in cycle N+1.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - data_in is sampled only on acceptance.
- Frame format:
  - Start bit 0.
  - DATA_BITS data bits, LSB first.
  - Optional parity bit: even = XOR of the data bits; odd = its inverse.
  - STOP_BITS stop bits of 1.
  - Every bit lasts exactly CLKS_PER_BIT clocks.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the FIFO is non-empty, pop, load the shift register, compute parity, set tx<=0, go to START.
  - START -> DATA after CLKS_PER_BIT clocks.
  - DATA: shift one bit every CLKS_PER_BIT clocks. After DATA_BITS bits go to PARITY (PARITY != 0) or STOP.
  - PARITY -> STOP after one bit time.
  - STOP: hold tx=1 for STOP_BITS*CLKS_PER_BIT clocks. On the last cycle, if the FIFO is non-empty, pop and go directly to START (tx<=0 at the next edge, zero gap). Otherwise go to IDLE.
- Latency: word accepted at edge E into an empty FIFO while IDLE -> FIFO pop and tx falling at edge E+1.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps. It is reloaded on every state entry; no drift across frames.
- Widths: the bit counter is sized for max(DATA_BITS, STOP_BITS). FIFO pointers use $clog2(FIFO_DEPTH) bits and wrap naturally.
- busy = (state != IDLE) || (fifo_level != 0).

Decomposition:
- Package uart_pkg holds:
  - parity encoding constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - the FSM state typedef/encoding;
  - the frame-length helper function (1 + DATA_BITS + (PARITY != 0) + STOP_BITS).
- One sub-module: sync_fifo (DEPTH, WIDTH; push/pop/full/empty/level). It is reusable by a future uart_rx.

Test Plan:
- 8N1 framing, MAIN_CLK=4, BAUD=1: push 0x41 -> tx low at edge after acceptance. Bits 0, then 1,0,0,0,0,0,1,0, then 1; each 4 clocks; frame 40 clocks; busy falls at the end.
- 8E1 / 8O1 framing: push 0x41 -> parity bit 0 (even) / 1 (odd) at clocks 36..39. Frame is 44 clocks.
- 7E2 framing (DATA_BITS=7, PARITY=1, STOP_BITS=2): push 0x57 -> data 1,1,1,0,1,0,1; parity 1; 8 clocks of stop. Frame is 44 clocks.
- FIFO full, FIFO_DEPTH=4, valid held with 0x41..0x46: 5 words accepted on consecutive edges (first one popped at E1). data_in_ready then low. It re-rises the cycle after the pop at frame-1 end. All 6 frames are sent in order.
- Back-to-back: 3 queued words -> the stop bit of each frame is high exactly 4 clocks, and the next start bit follows with no idle cycle.
- Reset mid-frame: assert rst_n low during data bit 3 with 2 words queued -> tx=1 asynchronously, fifo_level=0, busy=0. After release, no further frames until a new push.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM encoding and frame helper for the UART blocks
//
// Purpose: parity encodings, transmitter state type and frame-length helper,
//          shared by uart_tx_cfg and any future receiver.
// Ports:   none (package).
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Bits on the line for one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_sync_fifo.sv
// rtl/uart_tx_cfg_sync_fifo.sv - single-clock FIFO with occupancy count
//
// Purpose: DEPTH x WIDTH first-word-fall-through FIFO; pop_data always shows
//          the oldest entry. Pushes when full and pops when empty are ignored.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write request and word
//   pop, pop_data     read request and oldest word
//   full, empty       occupancy flags derived from the registered level
//   level             current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two, minimum 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are exactly log2(DEPTH) wide so they wrap without compare logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (level == (AW + 1)'(DEPTH));
  assign empty    = (level == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter with transmit FIFO
//
// Purpose: queues words over a valid/ready handshake and serialises them as
//          start / DATA_BITS (LSB first) / optional parity / STOP_BITS frames,
//          with back-to-back frames leaving no idle gap.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   data_in          word to transmit, sampled only when accepted
//   data_in_valid    producer offers data_in
//   data_in_ready    FIFO has room (from registered occupancy)
//   tx               serial line, idle high, registered
//   busy             frame in progress or words still queued
//   fifo_level       current FIFO occupancy
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int MAIN_CLK   = 12000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CPB  = MAIN_CLK / BAUD;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int MAXB = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int BW   = $clog2(MAXB);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  if (CPB < 1) begin : g_bad_baud
    $error("uart_tx_cfg: MAIN_CLK/BAUD must be at least 1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_par
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (frame_bits(DATA_BITS, PARITY, STOP_BITS) > 13) begin : g_bad_frame
    $error("uart_tx_cfg: frame longer than 13 bits");
  end

  uart_state_t          state_q, state_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 bit_end;
  logic                 start_frame;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (data_in_valid),
    .push_data (data_in),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // full is level==DEPTH on the registered count, so ready never depends on a same-cycle pop.
  assign data_in_ready = !fifo_full;
  assign busy          = (state_q != ST_IDLE) || (fifo_level != '0);
  assign tx            = tx_q;
  assign bit_end       = (cnt_q == CNT_LAST);

  // A new frame starts from IDLE, or directly from the last stop-bit cycle so
  // queued words go out with no idle gap.
  assign start_frame = !fifo_empty &&
                       ((state_q == ST_IDLE) ||
                        (state_q == ST_STOP && bit_end && bit_q == STOP_LAST));

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    pop     = 1'b0;

    // Timer wraps at each bit boundary, which is also every state entry.
    if (state_q != ST_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: ;
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
              bit_d   = '0;
            end
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
          bit_d   = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_frame) begin
      pop     = 1'b1;
      state_d = ST_START;
      tx_d    = 1'b0;
      shreg_d = fifo_data;
      par_d   = (^fifo_data) ^ (PARITY == PAR_ODD);
      cnt_d   = '0;
      bit_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
      shreg_q <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg in 8N1, 8E1, 8O1 and 7E2
module tb_uart_tx_cfg;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int cfg, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 60)
        $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", cfg, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int DB   = (g == 3) ? 7 : 8;
    localparam int PAR  = (g == 0) ? 0 : ((g == 2) ? 2 : 1);
    localparam int SB   = (g == 3) ? 2 : 1;
    localparam int FLEN = (g == 0) ? 10 : 11;
    // Hand-derived line bits (bit i = i-th bit time) for the literal frame.
    localparam logic [10:0] LIT = (g == 0) ? 11'h282 : (g == 1) ? 11'h482 :
                                  (g == 2) ? 11'h682 : 11'h7AE;
    localparam logic [8:0] LIT_WORD = (g == 3) ? 9'h057 : 9'h041;

    logic          rst_n;
    logic [DB-1:0] data_in;
    logic          valid;
    logic          ready;
    logic          tx;
    logic          busy;
    logic [2:0]    level;
    bit            done_f = 1'b0;

    uart_tx_cfg #(
      .MAIN_CLK   (4),
      .BAUD       (1),
      .DATA_BITS  (DB),
      .PARITY     (PAR),
      .STOP_BITS  (SB),
      .FIFO_DEPTH (DEPTH)
    ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .data_in       (data_in),
      .data_in_valid (valid),
      .data_in_ready (ready),
      .tx            (tx),
      .busy          (busy),
      .fifo_level    (level)
    );

    // Reference: a queue of waiting words and the per-clock line values of the
    // frame on the wire. Outputs are compared at negedge, then the model steps
    // to what must hold after the coming posedge.
    logic [DB-1:0] m_fifo[$];
    logic          m_line[$];

    always @(negedge clk) begin : model
      logic [DB-1:0] w;
      logic [DB-1:0] w2;
      logic          acc;
      logic          pb;
      if (!rst_n) begin
        m_fifo.delete();
        m_line.delete();
      end else begin
        chk("tx", g, tx, (m_line.size() > 0) ? m_line[0] : 1'b1);
        chk("busy", g, busy, (m_line.size() > 0) || (m_fifo.size() > 0));
        chk("level", g, level, m_fifo.size());
        chk("ready", g, ready, m_fifo.size() < DEPTH);
        acc = valid && (m_fifo.size() < DEPTH);
        w   = data_in;
        if (m_line.size() <= 1) begin
          m_line.delete();
          if (m_fifo.size() > 0) begin
            w2 = m_fifo.pop_front();
            pb = (PAR == 2) ? ~(^w2) : (^w2);
            for (int k = 0; k < CPB; k++) m_line.push_back(1'b0);
            for (int i = 0; i < DB; i++)
              for (int k = 0; k < CPB; k++) m_line.push_back(w2[i]);
            if (PAR != 0)
              for (int k = 0; k < CPB; k++) m_line.push_back(pb);
            for (int k = 0; k < SB * CPB; k++) m_line.push_back(1'b1);
          end
        end else begin
          void'(m_line.pop_front());
        end
        if (acc) m_fifo.push_back(w);
      end
    end

    task automatic wait_idle(input int limit);
      int c;
      c = 0;
      while (busy && c < limit) begin
        @(posedge clk);
        #1;
        c++;
      end
      chk("drain", g, busy, 1'b0);
    endtask

    initial begin : stim
      int          n;
      int          idx;
      int          quiet;
      int          acc_edge[6];
      bit          acc_now;
      logic [10:0] lit;
      logic [8:0]  wv;
      logic [31:0] rnd;

      lit     = LIT;
      rst_n   = 1'b0;
      valid   = 1'b0;
      data_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", g, tx, 1'b1);
      chk("rst_busy", g, busy, 1'b0);
      chk("rst_level", g, level, 3'd0);
      chk("rst_ready", g, ready, 1'b1);
      rst_n = 1'b1;

      // Single literal frame: tx low at the edge after acceptance.
      @(posedge clk);
      #1;
      wv      = LIT_WORD;
      data_in = wv[DB-1:0];
      valid   = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      n = 0;
      while (n < 200) begin
        @(posedge clk);
        #1;
        n++;
        if (n == 1) chk("latency_tx", g, tx, 1'b0);
        if (((n - 1) % CPB) == 1 && ((n - 1) / CPB) < FLEN)
          chk("lit_bit", g, tx, lit[(n - 1) / CPB]);
        if (!busy) break;
      end
      chk("frame_clks", g, n, FLEN * CPB + 1);

      // FIFO full: valid held for six words.
      @(posedge clk);
      #1;
      idx     = 0;
      n       = 0;
      wv      = 9'h041;
      data_in = wv[DB-1:0];
      valid   = 1'b1;
      while (idx < 6 && n < 400) begin
        acc_now = ready;
        @(posedge clk);
        #1;
        n++;
        if (acc_now) begin
          acc_edge[idx] = n;
          idx++;
          if (idx == 5) chk("full_ready_low", g, ready, 1'b0);
          wv      = 9'h041 + 9'(idx);
          data_in = wv[DB-1:0];
        end
      end
      valid = 1'b0;
      chk("full_accepts", g, idx, 6);
      for (int i = 0; i < 5; i++) chk("burst_edge", g, acc_edge[i], i + 1);
      chk("sixth_edge", g, acc_edge[5], FLEN * CPB + 3);
      wait_idle(800);

      // Randomised traffic.
      for (int c = 0; c < 400; c++) begin
        rnd     = $urandom;
        data_in = rnd[DB-1:0];
        valid   = ($urandom_range(0, 2) == 0);
        @(posedge clk);
        #1;
      end
      valid = 1'b0;
      wait_idle(1200);

      // Reset during data bit 3 of the first frame with two words queued.
      @(posedge clk);
      #1;
      valid = 1'b1;
      wv = 9'h041; data_in = wv[DB-1:0];
      @(posedge clk); #1;
      wv = 9'h042; data_in = wv[DB-1:0];
      @(posedge clk); #1;
      wv = 9'h043; data_in = wv[DB-1:0];
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (16) @(posedge clk);
      #2;
      chk("pre_rst_tx", g, tx, 1'b0);
      chk("pre_rst_level", g, level, 3'd2);
      rst_n = 1'b0;
      #1;
      chk("async_tx", g, tx, 1'b1);
      chk("async_level", g, level, 3'd0);
      chk("async_busy", g, busy, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      quiet = 0;
      for (int c = 0; c < 60; c++) begin
        @(posedge clk);
        #1;
        if (!tx || busy) quiet++;
      end
      chk("post_rst_quiet", g, quiet, 0);

      wv      = 9'h0A5;
      data_in = wv[DB-1:0];
      valid   = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      chk("restart_busy", g, busy, 1'b1);
      wait_idle(200);
      done_f = 1'b1;
    end
  end

  initial begin : top_ctl
    int cyc;
    cyc = 0;
    while (!(g_cfg[0].done_f && g_cfg[1].done_f && g_cfg[2].done_f && g_cfg[3].done_f)
           && cyc < 50000) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 50000) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d cycles expected fewer than 50000", cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
